f1_rd_ctrl: RTL and testbench

Read sequencer for the conv-layer-1 feature ROM: 32x32 8-bit image, 10-bit address, fixed 2-cycle read latency. On start it walks every 5x5 window of the 28x28 valid-convolution output in raster order. It issues the 25 tap addresses per window and re-aligns the returned ROM data with valid/first/last tags for the conv-1 PE array. One window is issued only when the PE signals ready, so the PE never receives a partial window it cannot accept.

---
 rtl/lenet_pkg.sv | 42 ++++
 rtl/f1_tag_pipe.sv | 41 ++++
 rtl/f1_rd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_f1_rd_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_pkg
//  Description : Shared constants and FSM encoding for the LeNet conv-layer-1
//                feature-ROM read path (32x32 8-bit image, 5x5 kernel).
//  Revision    : 1.0  initial release
// ============================================================================
package lenet_pkg;

    // Image / kernel geometry
    localparam int IMG_W     = 32;
    localparam int K         = 5;
    localparam int OUT_W     = IMG_W - K + 1;     // valid-convolution output size

    // ROM interface
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;
    localparam int F1_RD_LAT = 2;                 // address cycle to data cycle

    // Derived counter / tag widths
    localparam int RC_W      = $clog2(OUT_W);     // output row/col index
    localparam int KC_W      = $clog2(K);         // kernel row/col index
    localparam int DRAIN_W   = (F1_RD_LAT > 1) ? $clog2(F1_RD_LAT) : 1;
    localparam int TAG_W     = 3 + 2 * RC_W;      // {valid, first, last, row, col}

    // Read-sequencer state encoding
    localparam logic [2:0] C_ST_IDLE    = 3'd0;
    localparam logic [2:0] C_ST_WAIT_PE = 3'd1;
    localparam logic [2:0] C_ST_ISSUE   = 3'd2;
    localparam logic [2:0] C_ST_DRAIN   = 3'd3;
    localparam logic [2:0] C_ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = C_ST_IDLE,
        ST_WAIT_PE = C_ST_WAIT_PE,
        ST_ISSUE   = C_ST_ISSUE,
        ST_DRAIN   = C_ST_DRAIN,
        ST_DONE    = C_ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/f1_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : f1_tag_pipe
//  Description : DEPTH-stage shift register that delays the tap tag tuple
//                {valid, first, last, row, col} so it lines up with ROM data.
//                Asynchronous active-low clear drops every in-flight tag.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                i_tag  - tag generated in the address-issue cycle
//                o_tag  - tag delayed by DEPTH cycles
//  Revision    : 1.0  initial release
// ============================================================================
module f1_tag_pipe
    import lenet_pkg::*;
#(
    parameter int DEPTH = F1_RD_LAT,
    parameter int WIDTH = TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_tag,
    output logic [WIDTH-1:0] o_tag
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/f1_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : f1_rd_ctrl
//  Description : Read sequencer for the conv-1 feature ROM. Walks every KxK
//                window of the OUT_W x OUT_W output in raster order, issues
//                the K*K tap addresses of one window at a time (only when the
//                PE is ready) and tags the returning ROM data for the PE.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                start             - pass start pulse (sampled in IDLE only)
//                busy, done        - pass in progress / end-of-pass pulse
//                pe_ready          - PE can accept one whole window
//                f1_raddr/f1_rdata - ROM address (registered) / read data
//                pix_*             - tap data with valid/first/last/row/col
//  Revision    : 1.0  initial release
// ============================================================================
module f1_rd_ctrl
    import lenet_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              pe_ready,
    output logic [ADDR_W-1:0] f1_raddr,
    input  logic [DATA_W-1:0] f1_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              pix_first,
    output logic              pix_last,
    output logic [RC_W-1:0]   pix_row,
    output logic [RC_W-1:0]   pix_col
);

    localparam logic [KC_W-1:0]    C_K_LAST     = KC_W'(K - 1);
    localparam logic [RC_W-1:0]    C_OUT_LAST   = RC_W'(OUT_W - 1);
    localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(F1_RD_LAT - 1);
    // Next kernel row: back over K-1 columns, down one image row.
    localparam logic [ADDR_W-1:0]  C_KROW_STEP  = ADDR_W'(IMG_W - (K - 1));
    // Next output row: from base of column OUT_W-1 to column 0 one row down.
    localparam logic [ADDR_W-1:0]  C_OROW_STEP  = ADDR_W'(IMG_W - (OUT_W - 1));

    state_t              r_state, w_state_nxt;
    logic [RC_W-1:0]     r_orow, w_orow_nxt;
    logic [RC_W-1:0]     r_ocol, w_ocol_nxt;
    logic [KC_W-1:0]     r_kr, w_kr_nxt;
    logic [KC_W-1:0]     r_kc, w_kc_nxt;
    logic [DRAIN_W-1:0]  r_drain, w_drain_nxt;
    logic [ADDR_W-1:0]   r_base, w_base_nxt;
    logic [ADDR_W-1:0]   r_raddr, w_raddr_nxt;
    logic                w_issue;
    logic [TAG_W-1:0]    w_tag_in, w_tag_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_orow  <= '0;
            r_ocol  <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_drain <= '0;
            r_base  <= '0;
            r_raddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_orow  <= w_orow_nxt;
            r_ocol  <= w_ocol_nxt;
            r_kr    <= w_kr_nxt;
            r_kc    <= w_kc_nxt;
            r_drain <= w_drain_nxt;
            r_base  <= w_base_nxt;
            r_raddr <= w_raddr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_orow_nxt  = r_orow;
        w_ocol_nxt  = r_ocol;
        w_kr_nxt    = r_kr;
        w_kc_nxt    = r_kc;
        w_drain_nxt = r_drain;
        w_base_nxt  = r_base;
        w_raddr_nxt = r_raddr;
        w_issue     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_WAIT_PE;
                    w_orow_nxt  = '0;
                    w_ocol_nxt  = '0;
                    w_kr_nxt    = '0;
                    w_kc_nxt    = '0;
                    w_drain_nxt = '0;
                    w_base_nxt  = '0;
                end
            end

            ST_WAIT_PE: begin
                // Preload tap 0 so it is on the bus in the first ISSUE cycle.
                if (pe_ready) begin
                    w_state_nxt = ST_ISSUE;
                    w_raddr_nxt = r_base;
                end
            end

            ST_ISSUE: begin
                // The address on the bus now belongs to tap (r_kr, r_kc).
                w_issue = 1'b1;
                if (r_kc == C_K_LAST) begin
                    w_kc_nxt = '0;
                    if (r_kr == C_K_LAST) begin
                        w_kr_nxt    = '0;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_kr_nxt    = r_kr + KC_W'(1);
                        w_raddr_nxt = r_raddr + C_KROW_STEP;
                    end
                end else begin
                    w_kc_nxt    = r_kc + KC_W'(1);
                    w_raddr_nxt = r_raddr + ADDR_W'(1);
                end
            end

            ST_DRAIN: begin
                if (r_drain == C_DRAIN_LAST) begin
                    w_drain_nxt = '0;
                    if (r_orow == C_OUT_LAST && r_ocol == C_OUT_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_ocol == C_OUT_LAST) begin
                        w_ocol_nxt  = '0;
                        w_orow_nxt  = r_orow + RC_W'(1);
                        w_base_nxt  = r_base + C_OROW_STEP;
                        w_state_nxt = ST_WAIT_PE;
                    end else begin
                        w_ocol_nxt  = r_ocol + RC_W'(1);
                        w_base_nxt  = r_base + ADDR_W'(1);
                        w_state_nxt = ST_WAIT_PE;
                    end
                end else begin
                    w_drain_nxt = r_drain + DRAIN_W'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Row/col are zeroed on idle tags so the outputs read 0 between windows.
    assign w_tag_in = w_issue ? {1'b1,
                                 (r_kr == '0) && (r_kc == '0),
                                 (r_kr == C_K_LAST) && (r_kc == C_K_LAST),
                                 r_orow, r_ocol}
                              : '0;

    f1_tag_pipe #(
        .DEPTH (F1_RD_LAT),
        .WIDTH (TAG_W)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign {pix_valid, pix_first, pix_last, pix_row, pix_col} = w_tag_out;
    assign pix_data = f1_rdata;
    assign f1_raddr = r_raddr;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_f1_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_f1_rd_ctrl
//  Description : Self-checking bench for f1_rd_ctrl. A 2-cycle ROM model
//                returns address[7:0]; expected taps for a whole pass are
//                queued at start and popped whenever pix_valid is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_f1_rd_ctrl;
    import lenet_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
        logic [4:0] row;
        logic [4:0] col;
    } tap_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              pe_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] f1_raddr;
    logic [DATA_W-1:0] f1_rdata;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_first;
    logic              pix_last;
    logic [4:0]        pix_row;
    logic [4:0]        pix_col;
    logic [7:0]        rom_d1;
    logic [7:0]        rom_d2;

    tap_t exp_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;
    int   n_valid  = 0;
    int   n_done   = 0;
    int   cyc_n    = 0;
    int   last_cyc = -1;
    int   done_cyc = -1;

    always #5 clk = ~clk;

    // ROM: data = low byte of the address, two cycles after the address.
    always @(posedge clk) begin
        rom_d1 <= f1_raddr[7:0];
        rom_d2 <= rom_d1;
    end
    assign f1_rdata = rom_d2;

    f1_rd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pe_ready  (pe_ready),
        .f1_raddr  (f1_raddr),
        .f1_rdata  (f1_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_first (pix_first),
        .pix_last  (pix_last),
        .pix_row   (pix_row),
        .pix_col   (pix_col)
    );

    function automatic int exp_addr(input int r, input int c, input int kr, input int kc);
        return (r + kr) * IMG_W + (c + kc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    endtask

    task automatic push_pass();
        tap_t e;
        for (int r = 0; r < OUT_W; r++)
            for (int c = 0; c < OUT_W; c++)
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++) begin
                        e.data  = 8'(exp_addr(r, c, kr, kc));
                        e.first = (kr == 0) && (kc == 0);
                        e.last  = (kr == K - 1) && (kc == K - 1);
                        e.row   = 5'(r);
                        e.col   = 5'(c);
                        exp_q.push_back(e);
                    end
    endtask

    task automatic monitor();
        tap_t e;
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc_n;
        end
        if (pix_valid === 1'b1) begin
            n_valid++;
            if (pix_last === 1'b1) last_cyc = cyc_n;
            if (exp_q.size() == 0) begin
                check("unexpected_pix_valid", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("tap", 32'({pix_data, pix_first, pix_last, pix_row, pix_col}), 32'(e));
            end
        end
    endtask

    // One clock: inputs change at the falling edge, outputs sampled there.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        monitor();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pe_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_raddr", 32'(f1_raddr), 32'(0));
        check("rst_busy_done", 32'({busy, done}), 32'(0));
        check("rst_tags", 32'({pix_valid, pix_first, pix_last, pix_row, pix_col}), 32'(0));
        rst_n = 1'b1;
        cyc(); cyc();
        check("idle_busy", 32'(busy), 32'(0));

        // ---- Pass A: window 0 address walk, then reset inside window (3,5)
        pe_ready = 1'b1; start = 1'b1; push_pass();
        cyc();
        start = 1'b0;
        check("a_wait_busy", 32'(busy), 32'(1));
        for (int t = 0; t < K * K; t++) begin
            cyc();
            check("a_win0_addr", 32'(f1_raddr), 32'(exp_addr(0, 0, t / K, t % K)));
            if (t == 1) check("a_lat_pre", 32'(pix_valid), 32'(0));
            if (t == 2) check("a_lat_first", 32'({pix_valid, pix_first, pix_row, pix_col}),
                              32'({1'b1, 1'b1, 5'd0, 5'd0}));
        end
        repeat (28 * 89 + 10 - (K * K - 1)) cyc();
        check("a_win89_tap10", 32'(f1_raddr), 32'(exp_addr(3, 5, 2, 0)));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_raddr", 32'(f1_raddr), 32'(0));
        check("mid_rst_busy_done", 32'({busy, done}), 32'(0));
        check("mid_rst_tags", 32'({pix_valid, pix_first, pix_last, pix_row, pix_col}), 32'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            cyc();
            check("post_rst_valid", 32'(pix_valid), 32'(0));
        end
        check("post_rst_busy", 32'(busy), 32'(0));

        // ---- Pass B: stalls, ignored starts, full pass to done
        n_valid = 0;
        start = 1'b1; pe_ready = 1'b1; push_pass();
        cyc();
        start = 1'b0;
        check("b_wait_busy", 32'(busy), 32'(1));
        for (int t = 0; t < K * K; t++) begin
            cyc();
            check("b_win0_addr", 32'(f1_raddr), 32'(exp_addr(0, 0, t / K, t % K)));
        end
        pe_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("stall_raddr", 32'(f1_raddr), 32'(132));
            if (i >= 2) check("stall_no_valid", 32'(pix_valid), 32'(0));
        end
        pe_ready = 1'b1;
        for (int t = 0; t < K * K; t++) begin
            cyc();
            check("b_win1_addr", 32'(f1_raddr), 32'(exp_addr(0, 1, t / K, t % K)));
            if (t == 5)  pe_ready = 1'b0;
            if (t == 12) start = 1'b1;
            if (t == 13) start = 1'b0;
            if (t == K * K - 1) pe_ready = 1'b1;
        end
        repeat (28 * 782 - (K * K - 1)) cyc();
        check("last_base", 32'(f1_raddr), 32'(891));
        repeat (K * K - 1) cyc();
        check("last_tap", 32'(f1_raddr), 32'(1023));
        cyc(); cyc();
        check("final_last", 32'({pix_valid, pix_last, done}), 32'(3'b110));
        start = 1'b1;
        cyc();
        check("done_pulse", 32'({done, busy}), 32'(2'b11));
        start = 1'b0;
        repeat (40) cyc();
        check("end_busy", 32'(busy), 32'(0));
        check("done_count", 32'(n_done), 32'(1));
        check("valid_count", 32'(n_valid), 32'(OUT_W * OUT_W * K * K));
        check("last_to_done", 32'(done_cyc - last_cyc), 32'(1));
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
